// File: rtl/bufio_div_gen.sv
// Multi-channel divided-clock and SERDES-strobe generator clocked by the fast I/O clock.
// Runtime divide ratio, per-channel phase offset, clock enable, resync and lock indication.
module bufio_div_gen #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned RESET_DIVIDE = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CE,
    input  logic [CNT_W-1:0]        DIVIDE,
    input  logic [NUM_CH*CNT_W-1:0] PHASE,
    input  logic                    RESYNC,
    output logic [NUM_CH-1:0]       DIVCLK,
    output logic [NUM_CH-1:0]       SERDESSTROBE,
    output logic                    LOCKED,
    output logic [NUM_CH-1:0]       PHASE_ERR
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  d_q, d_d;
    logic              locked_q, locked_d;
    logic [NUM_CH-1:0] divclk_q, divclk_d;
    logic [NUM_CH-1:0] strobe_q, strobe_d;
    logic [NUM_CH-1:0] perr_q, perr_d;
    logic              upd;
    logic              div_ok;
    logic              wrap;

    assign div_ok = (DIVIDE >= CNT_W'(2));
    assign wrap   = (cnt_q == d_q - 1'b1);

    always_comb begin
        cnt_d    = cnt_q;
        d_d      = d_q;
        locked_d = locked_q;
        upd      = 1'b0;
        if (RESYNC) begin
            cnt_d    = '0;
            locked_d = 1'b0;
            upd      = 1'b1;
            if (div_ok) d_d = DIVIDE;
        end else if (CE) begin
            upd = 1'b1;
            if (wrap) begin
                cnt_d = '0;
                if (div_ok) d_d = DIVIDE;
                // lock on every unchanged-ratio wrap; a ratio change restarts the lock period
                locked_d = (d_d == d_q);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Channel outputs are evaluated against the next counter value and next ratio.
    always_comb begin
        logic [CNT_W-1:0] p;
        logic [CNT_W:0]   rel;
        logic [CNT_W:0]   half;
        divclk_d = divclk_q;
        strobe_d = strobe_q;
        perr_d   = perr_q;
        p        = '0;
        rel      = '0;
        half     = ({1'b0, d_d} + 1'b1) >> 1;
        if (upd) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                p = PHASE[i*CNT_W +: CNT_W];
                if (p >= d_d) begin
                    perr_d[i]   = 1'b1;
                    divclk_d[i] = 1'b0;
                    strobe_d[i] = 1'b0;
                end else begin
                    if (cnt_d >= p) rel = {1'b0, cnt_d} - {1'b0, p};
                    else            rel = {1'b0, cnt_d} + {1'b0, d_d} - {1'b0, p};
                    perr_d[i]   = 1'b0;
                    divclk_d[i] = (rel < half);
                    strobe_d[i] = (cnt_d == p);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q    <= '0;
            d_q      <= CNT_W'(RESET_DIVIDE);
            locked_q <= 1'b0;
            divclk_q <= '0;
            strobe_q <= '0;
            perr_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            locked_q <= locked_d;
            divclk_q <= divclk_d;
            strobe_q <= strobe_d;
            perr_q   <= perr_d;
        end
    end

    assign DIVCLK       = divclk_q;
    assign SERDESSTROBE = strobe_q;
    assign LOCKED       = locked_q;
    assign PHASE_ERR    = perr_q;

endmodule

// File: tb/tb_bufio_div_gen.sv
// Scoreboard bench for bufio_div_gen: directed scenarios followed by randomized traffic,
// checked against a behavioural period/phase model.
module tb_bufio_div_gen;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;

    logic                    CLK = 1'b0;
    logic                    RST = 1'b0;
    logic                    CE = 1'b0;
    logic [CNT_W-1:0]        DIVIDE = 4'd4;
    logic [NUM_CH*CNT_W-1:0] PHASE = '0;
    logic                    RESYNC = 1'b0;
    logic [NUM_CH-1:0]       DIVCLK, SERDESSTROBE, PHASE_ERR;
    logic                    LOCKED;

    bufio_div_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_DIVIDE(4)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .DIVIDE(DIVIDE), .PHASE(PHASE), .RESYNC(RESYNC),
        .DIVCLK(DIVCLK), .SERDESSTROBE(SERDESSTROBE), .LOCKED(LOCKED), .PHASE_ERR(PHASE_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [NUM_CH-1:0] dc;
        logic [NUM_CH-1:0] st;
        logic [NUM_CH-1:0] pe;
        logic              lk;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: position within the period, ratio, completed periods since last restart.
    int   m_cnt, m_d, m_full;
    exp_t m_out;

    function automatic exp_t calc();
        exp_t r;
        int p, rel;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            p = int'(PHASE[i*CNT_W +: CNT_W]);
            if (p >= m_d) begin
                r.pe[i] = 1'b1;
            end else begin
                rel = ((m_cnt - p) % m_d + m_d) % m_d;
                r.dc[i] = (rel < (m_d + 1) / 2);
                r.st[i] = (m_cnt == p);
            end
        end
        r.lk = (m_full > 0);
        return r;
    endfunction

    function automatic void model_edge();
        int nd;
        if (RESYNC) begin
            if (int'(DIVIDE) >= 2) m_d = int'(DIVIDE);
            m_cnt  = 0;
            m_full = 0;
            m_out  = calc();
        end else if (CE) begin
            if (m_cnt == m_d - 1) begin
                nd = (int'(DIVIDE) >= 2) ? int'(DIVIDE) : m_d;
                if (nd != m_d) begin
                    m_d    = nd;
                    m_full = 0;
                end else begin
                    m_full++;
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            m_out = calc();
        end
    endfunction

    task automatic tick();
        model_edge();
        q.push_back(m_out);
        @(posedge CLK);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic tick_until_cnt(input int c);
        for (int i = 0; i < 20 && m_cnt != c; i++) tick();
    endtask

    // Reset is raised between edges; the monitor checks it immediately and at the next edge.
    task automatic do_reset();
        m_cnt  = 0;
        m_d    = 4;
        m_full = 0;
        m_out  = '0;
        q.push_back('0);
        RST = 1'b1;
        q.push_back('0);
        @(posedge CLK);
        #2;
        RST = 1'b0;
    endtask

    initial begin
        exp_t e, got;
        forever begin
            @(posedge CLK or posedge RST);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = '{dc: DIVCLK, st: SERDESSTROBE, pe: PHASE_ERR, lk: LOCKED};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t: got dc=%b st=%b pe=%b lk=%b, expected dc=%b st=%b pe=%b lk=%b",
                             $time, got.dc, got.st, got.pe, got.lk, e.dc, e.st, e.pe, e.lk);
                end
            end
        end
    end

    initial begin
        #2;
        do_reset();
        CE = 1'b1; DIVIDE = 4'd4; PHASE = 8'h00;
        ticks(12);
        DIVIDE = 4'd5; PHASE = 8'h20;
        ticks(15);
        DIVIDE = 4'd4;
        ticks(10);
        tick_until_cnt(1);
        DIVIDE = 4'd6;
        ticks(16);
        PHASE = 8'h07;
        ticks(8);
        PHASE = 8'h03;
        ticks(8);
        tick_until_cnt(2);
        CE = 1'b0;
        ticks(3);
        CE = 1'b1;
        tick_until_cnt(3);
        RESYNC = 1'b1; PHASE = 8'h10;
        tick();
        RESYNC = 1'b0;
        ticks(8);
        RESYNC = 1'b1; CE = 1'b0;
        ticks(3);
        RESYNC = 1'b0; CE = 1'b1;
        ticks(2);
        do_reset();
        DIVIDE = 4'd1;
        ticks(10);
        DIVIDE = 4'd0;
        ticks(10);
        DIVIDE = 4'd15; PHASE = 8'hE0;
        ticks(20);
        for (int n = 0; n < 3000; n++) begin
            CE     = ($urandom % 8) != 0;
            RESYNC = ($urandom % 60) == 0;
            if ($urandom % 25 == 0) DIVIDE = CNT_W'($urandom % 16);
            if ($urandom % 30 == 0) PHASE  = 8'($urandom);
            if ($urandom % 500 == 0) do_reset();
            else tick();
        end
        RESYNC = 1'b0;
        @(posedge CLK);
        #3;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bufio_div_gen.md
Name: bufio_div_gen

Overview:
Parametrised successor to the single-channel dual-edge I/O clock divider model: a synchronous, single-edge, multi-channel divided-clock and SERDES-strobe generator driven from the fast I/O clock. It provides a runtime-selectable divide ratio, a per-channel phase offset, clock enable, resynchronisation and a lock indication. It sits between the I/O clock buffer and the SERDES/fabric logic in the simulation library.

Parameters:
NUM_CH, 2, number of independent DIVCLK/SERDESSTROBE channel pairs (1..8)
CNT_W, 4, width of divide-ratio and phase fields; ratios up to 2^CNT_W-1
RESET_DIVIDE, 4, divide ratio loaded into the active-ratio register at reset (2..2^CNT_W-1)

Ports:
CLK  input  1  fast I/O clock; all state on rising edge
RST  input  1  asynchronous, active-high reset
CE  input  1  count enable; low freezes counter and all registered outputs
DIVIDE  input  CNT_W  requested divide ratio; sampled at period wrap
PHASE  input  NUM_CH*CNT_W  per-channel phase offset; channel i uses bits [i*CNT_W +: CNT_W]
RESYNC  input  1  synchronous restart of the division sequence
DIVCLK  output  NUM_CH  per-channel divided clock
SERDESSTROBE  output  NUM_CH  per-channel one-CLK strobe, once per divided period
LOCKED  output  1  high once a full period has completed at a stable ratio
PHASE_ERR  output  NUM_CH  channel phase >= active ratio (channel disabled)

Behaviour:
- Reset (async, RST=1): cnt=0, active ratio D=RESET_DIVIDE, DIVCLK=0, SERDESSTROBE=0, LOCKED=0, PHASE_ERR=0. Effects are immediate, with no clock edge required.
- Counter: cnt counts 0..D-1 and wraps to 0. It advances only when CE=1.
- Ratio update: DIVIDE is sampled into D only at the edge where cnt wraps D-1 -> 0. Mid-period changes have no effect until the wrap.
  - DIVIDE of 0 or 1 at sample time: D keeps its previous value, and the request is ignored.
  - When D changes value, LOCKED drops on that edge.
- Channel i, with p = PHASE field i and rel = (cnt - p) mod D, computed at CNT_W+1 bits with no wrap error:
  - Registered outputs are computed from the next counter value, so they align with the cycle in which cnt holds that value.
  - SERDESSTROBE[i] = 1 exactly in the cycle where cnt == p.
  - DIVCLK[i] = 1 while rel < ceil(D/2), else 0. The high phase starts in the strobe cycle. Odd D gives a high phase one cycle longer than the low phase.
  - If p >= D: DIVCLK[i]=0, SERDESSTROBE[i]=0, PHASE_ERR[i]=1, evaluated every cycle.
  - PHASE is live, not shadowed; a change re-aligns the channel on the next cycle.
- LOCKED:
  - Set on the wrap edge that completes the first full period after reset, RESYNC or a D change.
  - Cleared by RST, RESYNC or a D change.
- RESYNC=1 at an edge (CE ignored):
  - cnt=0; DIVIDE is sampled into D if valid; LOCKED=0.
  - Channel outputs are computed for cnt=0, so a channel with p=0 strobes in the first cycle after the edge.
  - RESYNC held high keeps cnt at 0.
- CE=0: all registers hold. A wrap cannot occur, so a pending DIVIDE change waits.
- Simultaneous events: RST overrides everything. RESYNC overrides CE and counting. A D change on a wrap edge clears LOCKED even when the lock condition is also met on that edge.
- Width rules: all compares are unsigned; the mod is implemented as a conditional add of D.

Test Plan:
1. Reset, DIVIDE=4, PHASE={0,0}, CE=1 -> both channels have a period of 4 CLK; DIVCLK pattern 1,1,0,0; strobe in the cnt=0 cycle; LOCKED rises on the first wrap (4th edge after reset).
2. D=5, PHASE ch1=2 -> ch1 strobe at cnt=2; DIVCLK[1] high for cnt=2,3,4 and low for 0,1; ch0 high for 0,1,2.
3. DIVIDE changed 4->6 at cnt=1 -> period stays 4 until the wrap, then becomes 6; LOCKED drops at the wrap and re-asserts 6 cycles later.
4. PHASE ch0=7 with D=6 -> PHASE_ERR[0]=1, DIVCLK[0]=SERDESSTROBE[0]=0; setting PHASE=3 clears PHASE_ERR next cycle and the strobe appears at cnt=3.
5. CE low for 3 cycles at cnt=2 -> outputs frozen, and counting resumes at cnt=3; RESYNC pulse at cnt=3 -> cnt=0 next edge, LOCKED=0, and the p=0 strobe follows immediately.
6. RST asserted mid-period between clock edges -> all outputs 0 immediately; DIVIDE=1 or 0 requests leave D unchanged.
